// File: rtl/crossbar_pkg.sv
// Shared types and widths for the crossbar egress arbiter.
package crossbar_pkg;
    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int DEF_PORTS   = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_WAIT_SOP = 2'd2,
        ST_XFER     = 2'd3
    } xbar_state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first requester searching upward from last_i+1, wrapping.
module rr_priority_pick
    import crossbar_pkg::*;
#(
    parameter int P_PORTS = DEF_PORTS,
    parameter int P_IDX_W = 3
) (
    input  logic [P_PORTS-1:0] req_i,
    input  logic [P_IDX_W-1:0] last_i,
    output logic [P_IDX_W-1:0] idx_o,
    output logic               found_o
);
    always_comb begin
        int cand;
        cand    = 0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 1; i <= P_PORTS; i++) begin
            cand = int'(last_i) + i;
            if (cand >= P_PORTS) cand = cand - P_PORTS;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = P_IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/crossbar_arbiter.sv
// Egress-port arbiter: round-robin grant, AXIS packet mux with back-pressure,
// and a watchdog that releases the port if the granted point never starts.
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int P_PORTS   = DEF_PORTS,
    parameter int P_IDX_W   = 3,
    parameter int P_TIMEOUT = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [P_PORTS-1:0]             i_trans_req,
    output logic [P_PORTS-1:0]             o_trans_grant,
    input  logic [P_PORTS-1:0]             s_axis_tvalid,
    input  logic [AXIS_DATA_W*P_PORTS-1:0] s_axis_tdata,
    input  logic [P_PORTS-1:0]             s_axis_tlast,
    input  logic [AXIS_KEEP_W*P_PORTS-1:0] s_axis_tkeep,
    input  logic [P_PORTS-1:0]             s_axis_tuser,
    output logic [P_PORTS-1:0]             s_axis_tready,
    output logic                           m_axis_tvalid,
    output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
    output logic                           m_axis_tlast,
    output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
    output logic                           m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic                           o_busy,
    output logic [P_IDX_W-1:0]             o_grant_idx,
    output logic                           o_timeout
);
    localparam int              CNT_W    = $clog2(P_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);

    xbar_state_e        state_q, state_d;
    logic [P_IDX_W-1:0] last_q, last_d;
    logic [P_IDX_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P_IDX_W-1:0] pick_idx;
    logic               pick_found;
    logic               mux_active;
    logic               beat_acc;

    rr_priority_pick #(
        .P_PORTS(P_PORTS),
        .P_IDX_W(P_IDX_W)
    ) u_pick (
        .req_i  (i_trans_req),
        .last_i (last_q),
        .idx_o  (pick_idx),
        .found_o(pick_found)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            last_q  <= P_IDX_W'(P_PORTS - 1);
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mux_active  = (state_q == ST_WAIT_SOP) || (state_q == ST_XFER);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_grant_idx = sel_q;

    // Zero-latency mux; only the selected point ever sees ready.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        if (mux_active) begin
            m_axis_tvalid        = s_axis_tvalid[sel_q];
            m_axis_tdata         = s_axis_tdata[int'(sel_q)*AXIS_DATA_W +: AXIS_DATA_W];
            m_axis_tlast         = s_axis_tlast[sel_q];
            m_axis_tkeep         = s_axis_tkeep[int'(sel_q)*AXIS_KEEP_W +: AXIS_KEEP_W];
            m_axis_tuser         = s_axis_tuser[sel_q];
            s_axis_tready[sel_q] = m_axis_tready;
        end
    end

    assign beat_acc = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        o_trans_grant = '0;
        o_timeout     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                o_trans_grant[sel_q] = 1'b1;
                cnt_d                = '0;
                state_d              = ST_WAIT_SOP;
            end
            ST_WAIT_SOP: begin
                // A beat landing on the last watchdog cycle still counts.
                if (beat_acc) begin
                    if (m_axis_tlast) begin
                        last_d  = sel_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    o_timeout = 1'b1;
                    last_d    = sel_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (beat_acc && m_axis_tlast) begin
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule
